// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM control FSM: states, mux selects,
// ALU/cmd/cond codes and the data-processing command decode.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic [1:0] ctrl;   // ALUControl code
    logic       writes; // result goes to the register file
    logic       cmp;    // compare: all four flags, no writeback
    logic       arith;  // C/V meaningful
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
    alu_dec_t d;
    d = '{ctrl: ALU_ADD, writes: 1'b0, cmp: 1'b0, arith: 1'b0};
    case (cmd)
      CMD_ADD: d = '{ctrl: ALU_ADD, writes: 1'b1, cmp: 1'b0, arith: 1'b1};
      CMD_SUB: d = '{ctrl: ALU_SUB, writes: 1'b1, cmp: 1'b0, arith: 1'b1};
      CMD_AND: d = '{ctrl: ALU_AND, writes: 1'b1, cmp: 1'b0, arith: 1'b0};
      CMD_ORR: d = '{ctrl: ALU_ORR, writes: 1'b1, cmp: 1'b0, arith: 1'b0};
      CMD_CMP: d = '{ctrl: ALU_SUB, writes: 1'b0, cmp: 1'b1, arith: 1'b1};
      default: d = '{ctrl: ALU_ADD, writes: 1'b0, cmp: 1'b0, arith: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle ARM controller.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic [1:0]   AdrLow;
  logic         mem_ready;
  logic         PCWrite;
  logic         AdrSrc;
  logic         MemWrite;
  logic         IRWrite;
  logic [1:0]   ResultSrc;
  logic         ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ALUControl;
  logic [1:0]   ImmSrc;
  logic [1:0]   RegSrc;
  logic         RegWrite;
  logic [3:0]   be;

  modport master (
    input  Instr, ALUFlags, AdrLow, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite, be
  );

  modport slave (
    output Instr, ALUFlags, AdrLow, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite, be
  );
endinterface

// File: rtl/multicycle_ctrl_cond_check.sv
// ARM condition evaluation: cond[3:0] against NZCV. 1111 never passes.
module cond_check
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ok
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = !z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = !c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = !n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = !v;
      COND_HI: cond_ok = c && !z;
      COND_LS: cond_ok = !c || z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = !z && (n == v);
      COND_LE: cond_ok = z || (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM main control FSM with NZCV flags and condition gating.
// Optional MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE stall while mem_ready is low.
module multicycle_ctrl
  import arm_mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);
  state_t     state, next;
  logic [3:0] flags;
  logic       cond_ok, cond_pass, hold, unused;
  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  alu_dec_t   dec;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd    = bus.Instr[15:12];
  assign dec   = alu_decode(funct[4:1]);

  cond_check u_cond (.cond(cond), .flags(flags), .cond_ok(cond_pass));

`ifdef MEM_WAIT_EN
  assign hold   = !bus.mem_ready;
  assign unused = ^bus.Instr[19:16];
`else
  assign hold   = 1'b0;
  assign unused = ^{bus.Instr[19:16], bus.mem_ready};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_FETCH:    next = hold ? S_FETCH : S_DECODE;
      S_DECODE:
        case (op)
          OP_MEM:  next = S_MEMADR;
          OP_DP:   next = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   next = S_BRANCH;
          default: next = S_FETCH;
        endcase
      S_MEMADR:   next = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next = hold ? S_MEMREAD : S_MEMWB;
      S_MEMWRITE: next = hold ? S_MEMWRITE : S_FETCH;
      S_EXECUTER,
      S_EXECUTEI: next = S_ALUWB;
      default:    next = S_FETCH;
    endcase
  end

  // cond_ok is sampled once per instruction; flags only move on a passing DP op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags   <= 4'b0000;
      cond_ok <= 1'b0;
    end else begin
      if (state == S_DECODE) cond_ok <= cond_pass;
      if ((state == S_EXECUTER || state == S_EXECUTEI) && cond_ok) begin
        if (dec.cmp) begin
          flags <= bus.ALUFlags;
        end else if (funct[0]) begin
          flags[3:2] <= bus.ALUFlags[3:2];
          if (dec.arith) flags[1:0] <= bus.ALUFlags[1:0];
        end
      end
    end
  end

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_REG;
    bus.ALUControl = ALU_ADD;
    bus.RegWrite   = 1'b0;
    bus.ImmSrc     = op;
    bus.RegSrc     = {op == OP_MEM, op == OP_BR};
    bus.be         = funct[2] ? (4'b0001 << bus.AdrLow) : 4'b1111;
    case (state)
      S_FETCH: begin
        bus.IRWrite   = !hold;
        bus.PCWrite   = !hold;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: begin
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMREAD: bus.AdrSrc = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = cond_ok;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = cond_ok;
      end
      S_EXECUTER: bus.ALUControl = dec.ctrl;
      S_EXECUTEI: begin
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = dec.ctrl;
      end
      S_ALUWB: begin
        if (rd == 4'd15) bus.PCWrite  = cond_ok;
        else             bus.RegWrite = cond_ok && dec.writes;
      end
      S_BRANCH: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALURESULT;
        bus.PCWrite   = cond_ok;
      end
      default: ;
    endcase
    if (reset) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
    end
  end
endmodule
